// File: rtl/serial_addsub_pkg.sv
// Shared constants and types for the serial 16-bit add/subtract unit.
package serial_addsub_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned SLICE_W    = 4;
  localparam int unsigned NUM_SLICES = DATA_W / SLICE_W;

  localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub16_if.sv
// Operand/result bundle between operand select, the add/sub unit and flag writeback.
interface serial_addsub16_if
  import serial_addsub_pkg::*;
;
  logic              start;
  logic              op_sub;
  logic              sat_en;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              flag_z;
  logic              flag_v;
  logic              flag_n;

  modport master (
    output start, op_sub, sat_en, a, b,
    input  busy, done, result, flag_z, flag_v, flag_n
  );

  modport slave (
    input  start, op_sub, sat_en, a, b,
    output busy, done, result, flag_z, flag_v, flag_n
  );
endinterface

// File: rtl/serial_addsub16_nibble_cla.sv
// 4-bit carry-lookahead adder slice with signed-overflow output (carry into MSB ^ carry out).
module nibble_cla
  import serial_addsub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               ovfl
);
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[SLICE_W-1:0];
    cout = c[SLICE_W];
    ovfl = c[SLICE_W] ^ c[SLICE_W-1];
  end
endmodule

// File: rtl/serial_addsub16.sv
// Multi-cycle 16-bit add/subtract: one CLA nibble slice sequenced LSB first,
// carry rippled through a register, then optional signed saturation and Z/V/N flags.
module serial_addsub16
  import serial_addsub_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  serial_addsub16_if.slave   bus
);
  localparam logic [1:0] LAST_NIB = 2'(NUM_SLICES - 1);

  state_t            state;
  logic [1:0]        nib;
  logic              carry;
  logic              sat;
  logic              v_raw;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] psum;

  logic [SLICE_W-1:0] s_a;
  logic [SLICE_W-1:0] s_b;
  logic [SLICE_W-1:0] s_sum;
  logic               s_cout;
  logic               s_ovfl;
  logic [DATA_W-1:0]  fin_res;

  always_comb begin
    s_a = opa[{nib, 2'b00} +: SLICE_W];
    s_b = opb[{nib, 2'b00} +: SLICE_W];
  end

  nibble_cla u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout),
    .ovfl (s_ovfl)
  );

  // Overflow direction follows operand A's sign (B already inverted for subtract).
  always_comb begin
    fin_res = psum;
    if (sat && v_raw) fin_res = opa[DATA_W-1] ? SAT_NEG : SAT_POS;
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      nib        <= '0;
      carry      <= 1'b0;
      sat        <= 1'b0;
      v_raw      <= 1'b0;
      opa        <= '0;
      opb        <= '0;
      psum       <= '0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.flag_z <= 1'b0;
      bus.flag_v <= 1'b0;
      bus.flag_n <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opa   <= bus.a;
            opb   <= bus.op_sub ? ~bus.b : bus.b;
            carry <= bus.op_sub;
            sat   <= bus.sat_en;
            nib   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          psum[{nib, 2'b00} +: SLICE_W] <= s_sum;
          carry <= s_cout;
          if (nib == LAST_NIB) begin
            v_raw <= s_ovfl;
            state <= FIN;
          end else begin
            nib <= nib + 2'd1;
          end
        end
        FIN: begin
          bus.result <= fin_res;
          bus.flag_z <= (fin_res == '0);
          bus.flag_n <= fin_res[DATA_W-1];
          bus.flag_v <= v_raw;
          bus.done   <= 1'b1;
          nib        <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub16.sv
// Self-checking bench for serial_addsub16: directed boundaries, handshake, reset abort, random ops.
module tb_serial_addsub16;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  serial_addsub16_if bus ();

  serial_addsub16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: exact integer arithmetic, then range test for overflow.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic sub, input logic sat,
                                output logic [15:0] r, output logic z,
                                output logic v, output logic n);
    int sa, sb, full;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    full = sub ? sa - sb : sa + sb;
    v    = (full > 32767) || (full < -32768);
    if (sat && v) r = (full > 0) ? 16'h7FFF : 16'h8000;
    else          r = full[15:0];
    z = (r == 16'h0000);
    n = r[15];
  endfunction

  // Called #1 after the start edge; returns edges until done and busy samples before it.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc      = 0;
    busy_cnt = bus.busy ? 1 : 0;
    while (!bus.done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (!bus.done && bus.busy) busy_cnt++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic sub, input logic sat);
    logic [15:0] er;
    logic ez, ev, en;
    model(a, b, sub, sat, er, ez, ev, en);
    check({tag, "_result"}, 32'(bus.result), 32'(er));
    check({tag, "_z"}, 32'(bus.flag_z), 32'(ez));
    check({tag, "_v"}, 32'(bus.flag_v), 32'(ev));
    check({tag, "_n"}, 32'(bus.flag_n), 32'(en));
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic sat);
    bus.a = a; bus.b = b; bus.op_sub = sub; bus.sat_en = sat; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.a      = 16'($urandom);
    bus.b      = 16'($urandom);
    bus.op_sub = ~sub;
    bus.sat_en = ~sat;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic sat);
    int cyc, bc;
    @(negedge clk);
    start_op(a, b, sub, sat);
    wait_done(cyc, bc);
    check({tag, "_latency"}, 32'(cyc), 32'd5);
    check({tag, "_busy_cycles"}, 32'(bc), 32'd5);
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    check_result(tag, a, b, sub, sat);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int cyc, bc, dones;
    logic [15:0] res_at_done;
    n_checks = 0;
    n_pass   = 0;
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.sat_en = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", {29'd0, bus.flag_z, bus.flag_v, bus.flag_n}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0);
    run_op("pos_ovf_sat", 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    run_op("pos_ovf_wrap", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op("neg_ovf_sat", 16'h8000, 16'h0001, 1'b1, 1'b1);
    run_op("neg_ovf_wrap", 16'h8000, 16'h0001, 1'b1, 1'b0);
    run_op("sub_pos_ovf", 16'h0000, 16'h8000, 1'b1, 1'b1);
    run_op("sub_zero", 16'h0005, 16'h0005, 1'b1, 1'b0);
    run_op("carry_chain", 16'h0FFF, 16'h0001, 1'b0, 1'b0);
    run_op("add_neg_sat", 16'h8000, 16'h8000, 1'b0, 1'b1);

    // start pulses while busy must be ignored
    @(negedge clk);
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    bus.a = 16'hFFFF; bus.b = 16'h1234; bus.op_sub = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    res_at_done = '0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        dones++;
        res_at_done = bus.result;
      end
    end
    check("ignore_done_count", 32'(dones), 32'd1);
    check("ignore_result", 32'(res_at_done), 32'h0002);

    // start in the done cycle is accepted, giving a 6-cycle issue interval
    @(negedge clk);
    start_op(16'h0100, 16'h0200, 1'b0, 1'b0);
    wait_done(cyc, bc);
    check("b2b_first_latency", 32'(cyc), 32'd5);
    check_result("b2b_first", 16'h0100, 16'h0200, 1'b0, 1'b0);
    start_op(16'h1000, 16'h0001, 1'b1, 1'b0);
    wait_done(cyc, bc);
    check("b2b_second_latency", 32'(cyc), 32'd5);
    check_result("b2b_second", 16'h1000, 16'h0001, 1'b1, 1'b0);

    // load nonzero outputs, then abort an operation mid-RUN
    run_op("pre_reset", 16'h8000, 16'h0001, 1'b1, 1'b1);
    @(negedge clk);
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_flags", {29'd0, bus.flag_z, bus.flag_v, bus.flag_n}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_op("post_reset", 16'h0003, 16'h0004, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = (i % 8 == 0) ? ra : 16'($urandom);
      run_op("rand", ra, rb, 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_addsub16.md
# serial_addsub16

Multi-cycle 16-bit add/subtract unit for the ALU datapath. It sequences one 4-bit carry-lookahead slice over four nibbles, least significant first, and ripples the carry between passes in a register. It then applies optional signed saturation and produces the Z/V/N flags consumed by the flag register. The unit sits between operand selection (upstream) and ALU result muxing and flag writeback (downstream), and uses a start/done handshake.

## Interface
- No parameters. Width is fixed at 16 bits with 4-bit slices, taken from package constants.
- clk  in  1  system clock. All state updates on the rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- start  in  1  request a new operation. Sampled only in IDLE.
- op_sub  in  1  0 = a+b, 1 = a−b. Sampled with start.
- sat_en  in  1  1 = clamp the result on signed overflow. Sampled with start.
- a  in  16  operand A, two's complement. Sampled with start.
- b  in  16  operand B, two's complement. Sampled with start.
- busy  out  1  high while an operation is in flight (RUN or FIN).
- done  out  1  single-cycle pulse. Qualifies result and the flags.
- result  out  16  final sum, held until the next done.
- flag_z  out  1  result == 0. Held.
- flag_v  out  1  raw signed overflow, before saturation. Held.
- flag_n  out  1  result[15]. Held.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: four passes, nibble index nib = 0..3.
  - FIN: saturation and flag computation.
- IDLE & start:
  - Latch a into opa.
  - Latch b into opb, bitwise inverted if op_sub.
  - Carry register ← op_sub.
  - Latch sat_en; nib ← 0; go to RUN.
- RUN, each cycle:
  - Slice inputs: opa[4·nib+3:4·nib], opb[4·nib+3:4·nib], carry.
  - Slice sum goes to partial-sum nibble nib. Carry register ← slice carry-out.
  - On nib==3, also capture the slice overflow (carry into bit 15 XOR carry out of bit 15) as v_raw, then go to FIN.
  - Otherwise nib increments.
- FIN, one cycle:
  - If sat_en & v_raw: result ← 16'h7FFF when opa[15]==0, else 16'h8000.
  - Otherwise result ← partial sum.
  - flag_z and flag_n are computed on the final (post-saturation) result. flag_v ← v_raw.
  - done ← 1 for exactly one cycle. Return to IDLE.
- start while busy is ignored; it is neither queued nor flagged.
- The final carry-out is discarded; no carry flag is produced.
- Operand inputs may change freely after the start cycle.

## Timing
- Reset values:
  - State IDLE, nib 0, carry 0.
  - busy 0, done 0, result 16'h0000.
  - flag_z 0, flag_v 0, flag_n 0.
- Latency: start sampled at edge k; done is high in the cycle following edge k+5. The result is valid from that same cycle.
- busy is high from edge k through edge k+5. It is low in the done cycle.
- Throughput: start asserted in the done cycle is accepted (state is IDLE). Back-to-back operations issue every 6 cycles.
- Reset mid-RUN or mid-FIN:
  - Return immediately to IDLE; all outputs go to their reset values.
  - No done is produced for the aborted operation.
- Saturation boundaries:
  - Positive overflow clamps to 7FFF; negative overflow clamps to 8000.
  - 8000−0001 overflows negative.
  - 0000−8000 overflows positive.

## Structure
- Shared package serial_addsub_pkg holds:
  - state enum {IDLE, RUN, FIN}
  - DATA_W=16, SLICE_W=4, NUM_SLICES=4
  - SAT_POS=16'h7FFF, SAT_NEG=16'h8000
- One sub-module: nibble_cla, a 4-bit carry-lookahead slice with ports a, b, cin, sum, cout, ovfl. It is instantiated once.
- The top level contains the FSM, the operand and partial-sum registers, the nibble mux/demux, and saturation and flag logic.

## Test plan
- Basic add: add 16'h1234 + 16'h1111, sat_en=0 → result 16'h2345; Z=0, V=0, N=0. done exactly 5 cycles after the start edge, busy high 5 cycles.
- Positive overflow: add 16'h7FFF + 16'h0001.
  - sat_en=1 → 16'h7FFF, V=1, N=0.
  - Repeat with sat_en=0 → 16'h8000, V=1, N=1.
- Negative overflow: sub 16'h8000 − 16'h0001.
  - sat_en=1 → 16'h8000, V=1, N=1.
  - sat_en=0 → 16'h7FFF, V=1, N=0.
- Zero and cross-nibble carry:
  - sub 16'h0005 − 16'h0005 → 16'h0000, Z=1, V=0, N=0.
  - add 16'h0FFF + 16'h0001 → 16'h1000, carry crosses all nibbles.
- Handshake:
  - start with a=16'h0001, b=16'h0001, then pulse start with other operands while busy → ignored; done once, result 16'h0002.
  - start asserted in the done cycle → accepted; second done 6 cycles later.
- Reset: assert rst_n=0 during RUN (nib=2) → busy/done/result/flags go to 0 immediately, no done pulse. A following add 16'h0003 + 16'h0004 → 16'h0007.
